// File: rtl/comparator_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state
// encoding, result encoding and the step-counter width helper.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Result flags packed as {eq, gt, sm}; exactly one bit set after a compare.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b100;
    localparam logic [2:0] RES_GT   = 3'b010;
    localparam logic [2:0] RES_SM   = 3'b001;

    // Ceiling log2 of n (0 for n <= 1).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Step counter width; at least one bit so a single-step compare still has a register.
    function automatic int unsigned step_width(input int unsigned n);
        return (clog2(n) == 0) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/comparator_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice.
module comparator_digit #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             dgt,
    output logic             dlt
);

    // Digit-level greater/less flags; both low when the digits match.
    always_comb begin
        dgt = (a > b);
        dlt = (a < b);
    end

endmodule

// File: rtl/comparator_serial.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle.
// Signed operands are turned into offset-binary at load (MSB inverted) so
// the datapath only ever performs an unsigned compare.
// Optional macro COMPARATOR_SERIAL_EARLY_EXIT_EN: finish in the cycle the
// first differing digit is seen instead of always running all N steps.
module comparator_serial
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             sm
);

    localparam int unsigned N      = WIDTH / DIGIT;
    localparam int unsigned STEP_W = step_width(N);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_sa;
    logic [WIDTH-1:0]    r_sb;
    logic [STEP_W-1:0]   r_step;
    logic                r_decided;
    logic                r_dir_gt;
    logic                r_busy;
    logic                r_done;
    logic [2:0]          r_res;

    logic                w_dgt;
    logic                w_dlt;
    logic                w_diff;
    logic                w_load;
    logic                w_finish;
    logic [2:0]          w_res_nxt;

    comparator_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a   (r_sa[WIDTH-1 -: DIGIT]),
        .b   (r_sb[WIDTH-1 -: DIGIT]),
        .dgt (w_dgt),
        .dlt (w_dlt)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode, load/finish strobes and the final result.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        w_diff      = 1'b0;
        w_res_nxt   = r_res;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = COMPARE;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            COMPARE: begin
                w_diff = !r_decided && (w_dgt || w_dlt);
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
                w_finish = (r_step == LAST_STEP) || w_diff;
`else
                w_finish = (r_step == LAST_STEP);
`endif
                if (w_finish) begin
                    w_state_nxt = DONE;
                    if (r_decided) begin
                        w_res_nxt = r_dir_gt ? RES_GT : RES_SM;
                    end else if (w_dgt) begin
                        w_res_nxt = RES_GT;
                    end else if (w_dlt) begin
                        w_res_nxt = RES_SM;
                    end else begin
                        w_res_nxt = RES_EQ;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand shift registers, step counter, decision latch, outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa      <= '0;
            r_sb      <= '0;
            r_step    <= '0;
            r_decided <= 1'b0;
            r_dir_gt  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_res     <= RES_NONE;
        end else begin
            r_busy <= (w_state_nxt == COMPARE);
            r_done <= (w_state_nxt == DONE);
            if (w_finish) begin
                r_res <= w_res_nxt;
            end
            if (w_load) begin
                r_sa      <= signed_mode ? {~a[WIDTH-1], a[WIDTH-2:0]} : a;
                r_sb      <= signed_mode ? {~b[WIDTH-1], b[WIDTH-2:0]} : b;
                r_step    <= '0;
                r_decided <= 1'b0;
                r_dir_gt  <= 1'b0;
            end else if (r_state == COMPARE) begin
                if (w_diff) begin
                    r_decided <= 1'b1;
                    r_dir_gt  <= w_dgt;
                end
                r_sa   <= r_sa << DIGIT;
                r_sb   <= r_sb << DIGIT;
                r_step <= r_step + STEP_W'(1);
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign eq   = r_res[2];
    assign gt   = r_res[1];
    assign sm   = r_res[0];

endmodule

// File: tb/tb_comparator_serial.sv
// Directed and random bench for comparator_serial against an arithmetic model.
module tb_comparator_serial;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DIGIT = 2;
    localparam int unsigned N     = WIDTH / DIGIT;

    logic             clk;
    logic             rst;
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             sm;

    int checks = 0;
    int errors = 0;
    logic [2:0] prev = 3'b000;

    comparator_serial #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .eq          (eq),
        .gt          (gt),
        .sm          (sm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result {eq,gt,sm} from integer arithmetic.
    function automatic logic [2:0] exp_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic s);
        int xv;
        int yv;
        xv = int'(x) - ((s && x[WIDTH-1]) ? (1 << WIDTH) : 0);
        yv = int'(y) - ((s && y[WIDTH-1]) ? (1 << WIDTH) : 0);
        if (xv == yv) return 3'b100;
        if (xv > yv)  return 3'b010;
        return 3'b001;
    endfunction

    // Reference latency: cycle (after the accepting edge) in which done is high.
    function automatic int exp_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] d;
        int h;
        d = x ^ y;
        if (d == '0) return N + 1;
        h = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i]) h = i;
        end
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
        return (WIDTH - 1 - h) / DIGIT + 2;
`else
        return N + 1;
`endif
    endfunction

    // Present a request; caller is positioned just after a negedge.
    task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        a           = x;
        b           = y;
        signed_mode = s;
        start       = 1'b1;
    endtask

    // Follow a compare cycle by cycle; optionally pulse a stray start at cycle 'pulse'.
    task automatic wait_result(input int lat, input logic [2:0] er, input int pulse);
        bit got;
        got = 0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= int'(N) + 4; c++) begin
            if (c > 1) @(negedge clk);
            chk("busy", 32'(busy), 32'(c < lat));
            if (done) begin
                chk("latency", 32'(c), 32'(lat));
                chk("flags", 32'({eq, gt, sm}), 32'(er));
                prev = er;
                got  = 1;
                break;
            end
            chk("flags_held", 32'({eq, gt, sm}), 32'(prev));
            if (pulse != 0 && c == pulse) begin
                a     = 8'hFF;
                b     = 8'h00;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                       input int pulse);
        launch(x, y, s);
        wait_result(exp_lat(x, y), exp_res(x, y, s), pulse);
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rs;
        rst         = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        repeat (2) @(negedge clk);
        chk("reset_outs", 32'({busy, done, eq, gt, sm}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases including boundaries.
        run(8'h3C, 8'h3C, 1'b0, 0); idle_check();
        run(8'h80, 8'h7F, 1'b0, 0); idle_check();
        run(8'h80, 8'h7F, 1'b1, 0); idle_check();
        run(8'hC0, 8'h00, 1'b0, 0); idle_check();
        run(8'h00, 8'h00, 1'b0, 0); idle_check();
        run(8'hFF, 8'h00, 1'b0, 0); idle_check();
        run(8'hFF, 8'h01, 1'b1, 0); idle_check();

        // Start while busy is ignored.
        run(8'h01, 8'h02, 1'b0, 2); idle_check();

        // Reset in cycle 3 of a compare aborts it.
        launch(8'h40, 8'h10, 1'b0);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_outs", 32'({busy, done, eq, gt, sm}), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        prev = 3'b000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'({busy, done}), 32'd0);
        end
        run(8'h5A, 8'hA5, 1'b1, 0); idle_check();

        // Back-to-back: new start in the DONE cycle.
        run(8'h12, 8'h34, 1'b0, 0);
        run(8'h34, 8'h12, 1'b0, 0);
        run(8'h77, 8'h77, 1'b1, 0); idle_check();

        // Random operands, random mode, random back-to-back.
        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 2))
                0: rb = ra;
                1: rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                default: rb = WIDTH'($urandom);
            endcase
            rs = 1'($urandom);
            run(ra, rb, rs, 0);
            if ($urandom_range(0, 1) == 0) idle_check();
        end
        idle_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comparator_serial.md
Name: comparator_serial

Overview:
Parametrised, multi-cycle magnitude comparator that is the sequential successor to the 2-bit dataflow comparator. It compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, under a start/busy/done handshake. It supports unsigned and two's-complement modes and keeps registered eq/gt/sm flags until the next result. It targets area-constrained datapaths where a full-width single-cycle comparator is not wanted.

Parameters:
WIDTH, 8, operand width in bits; must be >= 2 and a multiple of DIGIT
DIGIT, 2, bits examined per COMPARE cycle; N = WIDTH/DIGIT steps

Ports:
clk  input  1  single clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a compare; accepted only when busy=0
signed_mode  input  1  sampled with start; 1 = two's complement, 0 = unsigned
a  input  WIDTH  operand A, sampled on the accepting edge
b  input  WIDTH  operand B, sampled on the accepting edge
busy  output  1  high while in COMPARE
done  output  1  one-cycle pulse when the result is valid
eq  output  1  a == b (registered, held)
gt  output  1  a > b (registered, held)
sm  output  1  a < b (registered, held)

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, eq=0, gt=0, sm=0; shift registers and step counter cleared. Reset mid-COMPARE aborts the operation, and no done is produced.
- States: IDLE, COMPARE, DONE.
  - IDLE, or DONE, with start=1 -> COMPARE. a and b load into shift regs, step=0, decided=0. When signed_mode=1, the MSB of both operands is inverted at load (offset-binary), so an unsigned compare is valid from then on.
  - COMPARE: each cycle the top DIGIT bits of both shift regs are compared; if decided=0 and the digits differ, latch dir (gt or lt) and set decided=1. Regs shift left by DIGIT and step increments.
  - COMPARE -> DONE after step N-1 (see Optional Feature for early exit).
  - DONE -> IDLE next cycle unless start=1, which starts a new compare back-to-back.
- Outputs:
  - eq, gt, sm update on the same edge that asserts done, with exactly one of them high.
  - Otherwise they hold their last value.
- Timing:
  - busy=1 exactly in COMPARE.
  - start while busy=1 is ignored; there is no queue.
  - Latency without early exit: start sampled at edge 0, done high during cycle N+1.
- Boundary values: all-zeros vs all-zeros gives eq=1. Unsigned max vs 0 gives gt=1. Signed min vs max gives sm=1.

Optional Feature:
Macro COMPARATOR_SERIAL_EARLY_EXIT_EN.
- Defined: COMPARE -> DONE in the cycle the first differing digit k (0 = most significant) is found, so done is high in cycle k+2. Equal operands still take N+1 cycles.
- Undefined: latency is always N+1 cycles; the decided result is frozen for the remaining steps.
- Result values are identical in both builds.

Decomposition:
- Package comparator_pkg holds:
  - State encodings: IDLE=2'd0, COMPARE=2'd1, DONE=2'd2.
  - The step-counter width function clog2(N).
  - Result encoding constants.
- Sub-module comparator_digit: combinational DIGIT-bit compare producing dgt/dlt. It is instantiated once, on the shift-register MSBs.

Test Plan:
- WIDTH=8, DIGIT=2, unsigned, a=8'h3C, b=8'h3C: done in cycle 5; eq=1, gt=0, sm=0; busy high cycles 1-4.
- signed_mode=0, a=8'h80, b=8'h7F: gt=1. Repeat with signed_mode=1: sm=1 (-128 < 127).
- a=8'hC0, b=8'h00: with the macro, done in cycle 2 and gt=1; without it, done in cycle 5 and gt=1.
- Start a=8'h01, b=8'h02, then pulse start with a=8'hFF, b=8'h00 in cycle 2: the second start is ignored, and the result is sm=1 in cycle 5.
- Assert rst during cycle 3 of a compare: all outputs are 0 immediately, with no done pulse. A new start after release works normally.
- Back-to-back: start held high in the DONE cycle: the new compare begins with no IDLE cycle, and the held flags change only at the next done.
